ibex_tlul_host_arb: RTL and testbench

//  Shares one TL-UL host port between the Ibex instruction and data req/gnt interfaces.
//  - Arbitrates the A channel and tags each request's a_source with the requester ID.
//  - Routes D-channel responses back by d_source.
//  - At most one outstanding transaction per requester, so at most two in flight in total.
//  - Sits between the Ibex core and the secure-boot crossbar host port.

---
 rtl/ibex_tlul_arb_pkg.sv | 82 ++++++++
 rtl/ibex_tlul_a_pack.sv | 41 ++++
 rtl/ibex_tlul_host_arb.sv | 143 ++++++++++++++
 tb/tb_ibex_tlul_host_arb.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_tlul_arb_pkg.sv
// ibex_tlul_arb_pkg: TL-UL types, requester IDs and helpers shared by the Ibex host arbiter
// and single-port adapters.  Revision 1.0
`default_nettype none

package ibex_tlul_arb_pkg;

    localparam int unsigned SRC_INSTR = 0;
    localparam int unsigned SRC_DATA  = 1;

    localparam logic [3:0] MUBI4_TRUE  = 4'h6;
    localparam logic [3:0] MUBI4_FALSE = 4'h9;

    typedef enum logic [2:0] {
        PUT_FULL_DATA    = 3'h0,
        PUT_PARTIAL_DATA = 3'h1,
        GET              = 3'h4
    } tl_a_op_e;

    typedef struct packed {
        logic [3:0] instr_type;
        logic [6:0] cmd_intg;
        logic [6:0] data_intg;
    } tl_a_user_t;

    typedef struct packed {
        logic       a_valid;
        tl_a_op_e   a_opcode;
        logic [2:0] a_param;
        logic [1:0] a_size;
        logic [7:0] a_source;
        logic [31:0] a_address;
        logic [3:0] a_mask;
        logic [31:0] a_data;
        tl_a_user_t a_user;
        logic       d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic       d_valid;
        logic [2:0] d_opcode;
        logic [2:0] d_param;
        logic [1:0] d_size;
        logic [7:0] d_source;
        logic       d_sink;
        logic [31:0] d_data;
        logic       d_error;
        logic       a_ready;
    } tl_d2h_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        instr;
    } arb_req_t;

    // Parity-check columns for the 7-bit command and data integrity codes.
    localparam logic [6:0][63:0] INTG_MASKS = '{
        64'h0000_0000_0F0F_F0F1, 64'h0000_01FF_3C3C_C3C2, 64'h0000_1E00_5555_AAA4,
        64'h0003_E0E0_6666_9998, 64'h007C_1C1C_8787_7870, 64'h0F83_0303_F0F0_0F00,
        64'hF07C_00FF_FF00_00FF
    };

    function automatic tl_a_op_e tl_opcode(input logic we, input logic [3:0] be, input logic ro);
        tl_a_op_e op;
        if (ro || !we)        op = GET;
        else if (be == 4'hF)  op = PUT_FULL_DATA;
        else                  op = PUT_PARTIAL_DATA;
        return op;
    endfunction

    function automatic logic [6:0] intg7(input logic [63:0] v);
        logic [6:0] r;
        r = '0;
        for (int i = 0; i < 7; i++) r[i] = ^(v & INTG_MASKS[i]);
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ibex_tlul_a_pack.sv
// ibex_tlul_a_pack: combinational packing of one requester's fields into a TL-UL A beat.
// Revision 1.0
`default_nettype none

module ibex_tlul_a_pack
    import ibex_tlul_arb_pkg::*;
#(
    parameter bit INSTR_RO = 1'b1
) (
    input  logic       a_valid,
    input  logic [7:0] source,
    input  arb_req_t   req,
    output tl_h2d_t    tl
);

    tl_a_op_e   op;
    logic [3:0] mask;
    logic [3:0] instr_type;

    assign op         = tl_opcode(req.we, req.be, req.instr && INSTR_RO);
    assign mask       = (op == GET) ? 4'hF : req.be;
    assign instr_type = req.instr ? MUBI4_TRUE : MUBI4_FALSE;

    always_comb begin
        tl                    = '0;
        tl.a_valid            = a_valid;
        tl.a_opcode           = op;
        tl.a_size             = 2'd2;
        tl.a_source           = source;
        tl.a_address          = req.addr;
        tl.a_mask             = mask;
        tl.a_data             = req.wdata;
        tl.a_user.instr_type  = instr_type;
        tl.a_user.cmd_intg    = intg7({21'd0, instr_type, req.addr, op, mask});
        tl.a_user.data_intg   = intg7({32'd0, req.wdata});
        tl.d_ready            = 1'b1;
    end

endmodule

`default_nettype wire

// File: rtl/ibex_tlul_host_arb.sv
// ibex_tlul_host_arb: shares one TL-UL host port between the Ibex instruction and data
// req/gnt interfaces, one outstanding transaction per side.  Revision 1.0
`default_nettype none

module ibex_tlul_host_arb
    import ibex_tlul_arb_pkg::*;
#(
    parameter bit ARB_RR   = 1'b1,
    parameter bit INSTR_RO = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        unexp_rsp_o,
    output tl_h2d_t     tl_o,
    input  tl_d2h_t     tl_i
);

    logic [1:0]  outst_q, outst_d;
    logic        lock_q, lock_sel_q, last_q;
    logic [1:0]  eligible;
    logic        sel, a_valid, grant;
    logic        rsp_id, rsp_hit;
    logic [1:0]  rvalid_q;
    logic [31:0] instr_rdata_q, data_rdata_q;
    logic        instr_err_q, data_err_q, unexp_q;
    arb_req_t    req_sel;

    // Gating with rst_ni keeps the A channel and grants quiet while reset is asserted.
    assign eligible[SRC_INSTR] = rst_ni && instr_req_i && !outst_q[SRC_INSTR];
    assign eligible[SRC_DATA]  = rst_ni && data_req_i  && !outst_q[SRC_DATA];
    assign a_valid             = rst_ni && (lock_q || (|eligible));
    assign grant               = a_valid && tl_i.a_ready;

    always_comb begin
        sel = 1'b0;
        if (lock_q)               sel = lock_sel_q;
        else if (&eligible)       sel = ARB_RR ? ~last_q : 1'b1;
        else                      sel = eligible[SRC_DATA];
    end

    always_comb begin
        req_sel = '0;
        if (sel) begin
            req_sel.we    = data_we_i;
            req_sel.be    = data_be_i;
            req_sel.addr  = data_addr_i;
            req_sel.wdata = data_wdata_i;
            req_sel.instr = 1'b0;
        end else begin
            req_sel.we    = 1'b0;
            req_sel.be    = 4'hF;
            req_sel.addr  = instr_addr_i;
            req_sel.wdata = '0;
            req_sel.instr = 1'b1;
        end
    end

    ibex_tlul_a_pack #(
        .INSTR_RO (INSTR_RO)
    ) u_a_pack (
        .a_valid (a_valid),
        .source  ({7'd0, sel}),
        .req     (req_sel),
        .tl      (tl_o)
    );

    assign instr_gnt_o = grant && !sel;
    assign data_gnt_o  = grant &&  sel;

    assign rsp_id  = tl_i.d_source[0];
    assign rsp_hit = tl_i.d_valid && (tl_i.d_source[7:1] == 7'd0) && outst_q[rsp_id];

    // A response and a grant never target the same ID, so both updates can apply together.
    always_comb begin
        outst_d = outst_q;
        if (rsp_hit) outst_d[rsp_id] = 1'b0;
        if (grant)   outst_d[sel]    = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outst_q       <= '0;
            lock_q        <= 1'b0;
            lock_sel_q    <= 1'b0;
            last_q        <= 1'b0;
            rvalid_q      <= '0;
            instr_rdata_q <= '0;
            data_rdata_q  <= '0;
            instr_err_q   <= 1'b0;
            data_err_q    <= 1'b0;
            unexp_q       <= 1'b0;
        end else begin
            outst_q <= outst_d;
            if (grant) begin
                lock_q <= 1'b0;
                last_q <= sel;
            end else if (a_valid) begin
                lock_q     <= 1'b1;
                lock_sel_q <= sel;
            end
            rvalid_q[SRC_INSTR] <= rsp_hit && !rsp_id;
            rvalid_q[SRC_DATA]  <= rsp_hit &&  rsp_id;
            if (rsp_hit && !rsp_id) begin
                instr_rdata_q <= tl_i.d_data;
                instr_err_q   <= tl_i.d_error;
            end
            if (rsp_hit && rsp_id) begin
                data_rdata_q <= tl_i.d_data;
                data_err_q   <= tl_i.d_error;
            end
            unexp_q <= tl_i.d_valid && !rsp_hit;
        end
    end

    assign instr_rvalid_o = rvalid_q[SRC_INSTR];
    assign data_rvalid_o  = rvalid_q[SRC_DATA];
    assign instr_rdata_o  = instr_rdata_q;
    assign data_rdata_o   = data_rdata_q;
    assign instr_err_o    = instr_err_q;
    assign data_err_o     = data_err_q;
    assign unexp_rsp_o    = unexp_q;

    logic unused_d;
    assign unused_d = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size, tl_i.d_sink};

endmodule

`default_nettype wire

// File: tb/tb_ibex_tlul_host_arb.sv
// tb_ibex_tlul_host_arb: directed stimulus with a per-cycle reference model and literal checks.
`default_nettype none
`timescale 1ns/1ps

module tb_ibex_tlul_host_arb;
    import ibex_tlul_arb_pkg::*;

    localparam bit ARB_RR   = 1'b1;
    localparam bit INSTR_RO = 1'b1;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_rdata_o;
    logic        data_req, data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr, data_wdata;
    logic        data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0] data_rdata_o;
    logic        unexp_rsp_o;
    tl_h2d_t     tl_o;
    tl_d2h_t     tl_in;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    ibex_tlul_host_arb #(.ARB_RR(ARB_RR), .INSTR_RO(INSTR_RO)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .instr_req_i    (instr_req),
        .instr_addr_i   (instr_addr),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .instr_err_o    (instr_err_o),
        .data_req_i     (data_req),
        .data_we_i      (data_we),
        .data_be_i      (data_be),
        .data_addr_i    (data_addr),
        .data_wdata_i   (data_wdata),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .data_err_o     (data_err_o),
        .unexp_rsp_o    (unexp_rsp_o),
        .tl_o           (tl_o),
        .tl_i           (tl_in)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: which requester must be on the bus and what each response produces.
    bit          m_out [2];
    bit          m_hold;
    int          m_hold_id;
    int          m_last;
    bit          m_rv [2];
    logic [31:0] m_rd [2];
    bit          m_er [2];
    bit          m_unexp;

    function automatic int pick(input bit e0, input bit e1, input int last);
        if (e0 && e1) return ARB_RR ? (1 - last) : 1;
        return e1 ? 1 : 0;
    endfunction

    always @(negedge clk_i) begin : compare
        bit e0, e1, av, hit;
        int w, id, op;
        if (!rst_ni) begin
            chk("rst_a_valid", 32'(tl_o.a_valid), 0);
            chk("rst_instr_gnt", 32'(instr_gnt_o), 0);
            chk("rst_data_gnt", 32'(data_gnt_o), 0);
            chk("rst_instr_rvalid", 32'(instr_rvalid_o), 0);
            chk("rst_data_rvalid", 32'(data_rvalid_o), 0);
            chk("rst_instr_rdata", instr_rdata_o, 0);
            chk("rst_data_rdata", data_rdata_o, 0);
            chk("rst_errs", 32'({instr_err_o, data_err_o}), 0);
            chk("rst_unexp", 32'(unexp_rsp_o), 0);
            m_out = '{0, 0}; m_hold = 0; m_hold_id = 0; m_last = 0;
            m_rv = '{0, 0}; m_rd = '{0, 0}; m_er = '{0, 0}; m_unexp = 0;
        end else begin
            e0 = instr_req && !m_out[0];
            e1 = data_req && !m_out[1];
            av = m_hold || e0 || e1;
            w  = m_hold ? m_hold_id : pick(e0, e1, m_last);
            chk("m_a_valid", 32'(tl_o.a_valid), 32'(av));
            chk("m_instr_gnt", 32'(instr_gnt_o), 32'(av && tl_in.a_ready && w == 0));
            chk("m_data_gnt", 32'(data_gnt_o), 32'(av && tl_in.a_ready && w == 1));
            if (av) begin
                op = (w == 0 || !data_we) ? 4 : ((data_be == 4'hF) ? 0 : 1);
                chk("m_a_source", 32'(tl_o.a_source), 32'(w));
                chk("m_a_opcode", 32'(tl_o.a_opcode), 32'(op));
                chk("m_a_mask", 32'(tl_o.a_mask), (op == 4) ? 32'hF : 32'(data_be));
                chk("m_a_address", tl_o.a_address, (w == 0) ? instr_addr : data_addr);
                chk("m_a_size_param", 32'({tl_o.a_size, tl_o.a_param}), 32'h10);
                chk("m_instr_type", 32'(tl_o.a_user.instr_type), (w == 0) ? 32'h6 : 32'h9);
                if (op != 4) chk("m_a_data", tl_o.a_data, data_wdata);
            end
            chk("m_instr_rvalid", 32'(instr_rvalid_o), 32'(m_rv[0]));
            chk("m_data_rvalid", 32'(data_rvalid_o), 32'(m_rv[1]));
            chk("m_instr_rdata", instr_rdata_o, m_rd[0]);
            chk("m_data_rdata", data_rdata_o, m_rd[1]);
            chk("m_instr_err", 32'(instr_err_o), 32'(m_er[0]));
            chk("m_data_err", 32'(data_err_o), 32'(m_er[1]));
            chk("m_unexp", 32'(unexp_rsp_o), 32'(m_unexp));
            // Advance the model across the coming rising edge.
            id  = int'(tl_in.d_source[0]);
            hit = tl_in.d_valid && (tl_in.d_source[7:1] == 7'd0) && m_out[id];
            m_rv    = '{0, 0};
            m_unexp = tl_in.d_valid && !hit;
            if (hit) begin
                m_rv[id] = 1; m_rd[id] = tl_in.d_data; m_er[id] = tl_in.d_error; m_out[id] = 0;
            end
            if (av && tl_in.a_ready) begin
                m_out[w] = 1; m_hold = 0; m_last = w;
            end else if (av) begin
                m_hold = 1; m_hold_id = w;
            end
        end
    end

    task automatic settle();
        #1;
    endtask

    // One clock: requesters drop req after a grant, D beats last a single cycle.
    task automatic step();
        bit ig, dg;
        @(negedge clk_i);
        ig = instr_gnt_o;
        dg = data_gnt_o;
        @(posedge clk_i);
        #1;
        if (ig) instr_req = 1'b0;
        if (dg) data_req = 1'b0;
        tl_in.d_valid = 1'b0;
    endtask

    task automatic dbeat(input logic [7:0] src, input logic [31:0] d, input logic err);
        tl_in.d_valid  = 1'b1;
        tl_in.d_source = src;
        tl_in.d_data   = d;
        tl_in.d_error  = err;
    endtask

    task automatic dreq(input logic we, input logic [3:0] be, input logic [31:0] a,
                        input logic [31:0] wd);
        data_req = 1'b1; data_we = we; data_be = be; data_addr = a; data_wdata = wd;
    endtask

    initial begin
        rst_ni = 1'b0;
        instr_req = 0; instr_addr = 0;
        data_req = 0; data_we = 0; data_be = 0; data_addr = 0; data_wdata = 0;
        tl_in = '0;
        tl_in.a_ready = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        step();

        // Lone instruction fetch, response two cycles after the grant.
        instr_req = 1; instr_addr = 32'h1000;
        settle();
        chk("t1_instr_gnt", 32'(instr_gnt_o), 1);
        chk("t1_a_source", 32'(tl_o.a_source), 0);
        chk("t1_opcode_get", 32'(tl_o.a_opcode), 4);
        step();
        step();
        dbeat(8'h00, 32'hDEADBEEF, 1'b0);
        step();
        chk("t1_rvalid", 32'(instr_rvalid_o), 1);
        chk("t1_rdata", instr_rdata_o, 32'hDEADBEEF);
        step();
        chk("t1_rvalid_pulse", 32'(instr_rvalid_o), 0);

        // Tie with last winner INSTR: data first, instr next cycle.
        instr_req = 1; instr_addr = 32'h2000;
        dreq(1'b0, 4'hF, 32'h3000, 32'h0);
        settle();
        chk("t2_data_first", 32'({data_gnt_o, instr_gnt_o}), 32'b10);
        chk("t2_src_data", 32'(tl_o.a_source), 1);
        step();
        chk("t2_instr_next", 32'({data_gnt_o, instr_gnt_o}), 32'b01);
        step();
        dbeat(8'h01, 32'hAAAA0001, 1'b0);
        step();
        dbeat(8'h00, 32'hBBBB0002, 1'b1);
        settle();
        chk("t2_data_rdata", data_rdata_o, 32'hAAAA0001);
        step();
        chk("t2_instr_err", 32'(instr_err_o), 1);
        step();

        // Back-pressure: the locked data request holds the A channel.
        tl_in.a_ready = 0;
        dreq(1'b1, 4'hF, 32'h4000, 32'h55);
        settle();
        chk("t3_c1_wait", 32'({tl_o.a_valid, data_gnt_o}), 32'b10);
        step();
        instr_req = 1; instr_addr = 32'h5000;
        settle();
        chk("t3_c2_addr", tl_o.a_address, 32'h4000);
        step();
        chk("t3_c3_src", 32'(tl_o.a_source), 1);
        step();
        tl_in.a_ready = 1;
        settle();
        chk("t3_c4_gnt", 32'({data_gnt_o, instr_gnt_o}), 32'b10);
        chk("t3_c4_putfull", 32'(tl_o.a_opcode), 0);
        step();
        chk("t3_instr_after", 32'(instr_gnt_o), 1);
        step();

        // Responses DATA then INSTR, the latter alongside a new data grant.
        dbeat(8'h01, 32'h11110000, 1'b0);
        dreq(1'b1, 4'h3, 32'h6000, 32'h12345678);
        settle();
        chk("t5_no_gnt_outst", 32'(data_gnt_o), 0);
        step();
        dbeat(8'h00, 32'h22220000, 1'b0);
        settle();
        chk("t5_data_rvalid", 32'(data_rvalid_o), 1);
        chk("t4_partial", 32'({data_gnt_o, 1'b0, tl_o.a_opcode, tl_o.a_mask}), 32'h113);
        chk("t4_wdata", tl_o.a_data, 32'h12345678);
        step();
        chk("t5_instr_only", 32'({instr_rvalid_o, data_rvalid_o}), 32'b10);
        dbeat(8'h01, 32'h0, 1'b0);
        step();
        dreq(1'b1, 4'hF, 32'h7000, 32'hCAFEF00D);
        settle();
        chk("t4_full", 32'({data_gnt_o, 1'b0, tl_o.a_opcode, tl_o.a_mask}), 32'h10F);
        step();
        dbeat(8'h01, 32'h0, 1'b0);
        step();
        step();

        // Unexpected beats and reset in mid-transaction.
        dbeat(8'h00, 32'h99, 1'b0);
        step();
        chk("t6_unexp", 32'({unexp_rsp_o, instr_rvalid_o}), 32'b10);
        dbeat(8'h03, 32'h98, 1'b0);
        step();
        chk("t6_unexp_src", 32'(unexp_rsp_o), 1);
        instr_req = 1; instr_addr = 32'h8000;
        settle();
        chk("t6_gnt", 32'(instr_gnt_o), 1);
        step();
        instr_req = 1; instr_addr = 32'h8004;
        rst_ni = 0;
        settle();
        chk("t6_rst_quiet", 32'({tl_o.a_valid, instr_gnt_o}), 0);
        step();
        step();
        instr_req = 0;
        rst_ni = 1;
        dbeat(8'h00, 32'h77, 1'b0);
        step();
        chk("t6_late_unexp", 32'({unexp_rsp_o, instr_rvalid_o}), 32'b10);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
